// File: rtl/mips_mon_pkg.sv
// Shared types and status encodings for the MIPS run monitor.
package mips_mon_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RESET_HOLD = 2'd1,
    RUN        = 2'd2,
    DONE       = 2'd3
  } run_state_t;

  localparam logic [1:0] STATUS_NONE    = 2'b00;
  localparam logic [1:0] STATUS_HALT    = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

endpackage

// File: rtl/mips_run_monitor_if.sv
// Trace read port: the debug side (master) requests an entry and the
// monitor (slave) answers one cycle later with pc/alu data and a valid pulse.
interface mips_run_monitor_if #(
  parameter int PC_WIDTH    = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int TRACE_DEPTH = 16
);
  localparam int AW = $clog2(TRACE_DEPTH);

  logic                  trace_rd_en;
  logic [AW-1:0]         trace_rd_addr;
  logic [PC_WIDTH-1:0]   trace_pc;
  logic [DATA_WIDTH-1:0] trace_alu;
  logic                  trace_valid;

  modport master (
    output trace_rd_en, trace_rd_addr,
    input  trace_pc, trace_alu, trace_valid
  );

  modport slave (
    input  trace_rd_en, trace_rd_addr,
    output trace_pc, trace_alu, trace_valid
  );
endinterface

// File: rtl/mips_trace_buf.sv
// Circular trace buffer of (pc, alu) samples with oldest-relative,
// registered reads. Reads see the contents from before a same-cycle write.
module mips_trace_buf #(
  parameter int PC_WIDTH    = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        wr_en,
  input  logic [PC_WIDTH-1:0]         wr_pc,
  input  logic [DATA_WIDTH-1:0]       wr_alu,
  output logic [$clog2(TRACE_DEPTH):0] count,
  mips_run_monitor_if.slave           rd
);
  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int CW = AW + 1;

  logic [PC_WIDTH-1:0]   pc_mem  [TRACE_DEPTH];
  logic [DATA_WIDTH-1:0] alu_mem [TRACE_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         oldest;
  logic [AW-1:0]         rd_phys;
  logic                  full;
  logic                  rd_hit;

  // Once full, the write pointer also marks the oldest entry.
  assign full    = (count == CW'(TRACE_DEPTH));
  assign oldest  = full ? wr_ptr : '0;
  assign rd_phys = oldest + rd.trace_rd_addr;
  assign rd_hit  = ({1'b0, rd.trace_rd_addr} < count);

  // Write pointer wraps naturally; count saturates at the depth.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (!full) count <= count + CW'(1);
    end
  end

  // Sample storage, left unreset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr]  <= wr_pc;
      alu_mem[wr_ptr] <= wr_alu;
    end
  end

  // Registered read port; entries past the valid count read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd.trace_pc    <= '0;
      rd.trace_alu   <= '0;
      rd.trace_valid <= 1'b0;
    end else begin
      rd.trace_valid <= rd.trace_rd_en;
      if (rd.trace_rd_en) begin
        rd.trace_pc  <= rd_hit ? pc_mem[rd_phys]  : '0;
        rd.trace_alu <= rd_hit ? alu_mem[rd_phys] : '0;
      end
    end
  end
endmodule

// File: rtl/mips_run_monitor.sv
// Run controller for the MIPS core: sequences CPU reset, counts run
// cycles, detects halt (PC stuck) or timeout, and records a trace.
module mips_run_monitor
  import mips_mon_pkg::*;
#(
  parameter int PC_WIDTH    = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int RST_CYCLES  = 4,
  parameter int MAX_CYCLES  = 2000,
  parameter int STALL_LIMIT = 8,
  parameter int TRACE_DEPTH = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [PC_WIDTH-1:0]          pc_in,
  input  logic [DATA_WIDTH-1:0]        alu_in,
  output logic                         cpu_rst_n,
  output logic                         running,
  output logic                         done,
  output logic [1:0]                   status,
  output logic [CNT_WIDTH-1:0]         cycle_count,
  output logic [$clog2(TRACE_DEPTH):0] trace_count,
  mips_run_monitor_if.slave            trace_bus
);
  localparam int HW = $clog2(RST_CYCLES + 1);
  localparam int SW = $clog2(STALL_LIMIT + 1);

  if (RST_CYCLES < 1) begin : g_bad_rst
    $error("RST_CYCLES must be at least 1");
  end
  if (STALL_LIMIT < 1) begin : g_bad_stall
    $error("STALL_LIMIT must be at least 1");
  end
  if (MAX_CYCLES < 1 || (64'(MAX_CYCLES) >> CNT_WIDTH) != 64'd0) begin : g_bad_max
    $error("MAX_CYCLES must be at least 1 and fit in CNT_WIDTH");
  end
  if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("TRACE_DEPTH must be a power of 2, at least 2");
  end

  run_state_t             state, state_next;
  logic [HW-1:0]          hold_cnt, hold_next;
  logic [1:0]             status_next;
  logic                   run_clear;
  logic [CNT_WIDTH-1:0]   cycle_inc;
  logic [SW-1:0]          stall_cnt, stall_next;
  logic [PC_WIDTH-1:0]    prev_pc;
  logic                   prev_valid;
  logic                   stall_inc;
  logic                   halt;
  logic                   timeout;
  logic                   in_run;

  assign in_run      = (state == RUN);
  assign cpu_rst_n   = in_run;
  assign running     = in_run;
  assign done        = (state == DONE);
  assign cycle_inc   = cycle_count + CNT_WIDTH'(1);
  assign stall_inc   = prev_valid && (pc_in == prev_pc);
  assign stall_next  = stall_inc ? stall_cnt + SW'(1) : '0;
  assign halt        = stall_inc && (stall_next == SW'(STALL_LIMIT));
  assign timeout     = (cycle_inc == CNT_WIDTH'(MAX_CYCLES));

  // State, reset-hold counter and status register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      status   <= STATUS_NONE;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      status   <= status_next;
    end
  end

  // Next-state logic; halt takes priority over timeout on the same edge.
  always_comb begin
    state_next  = state;
    hold_next   = hold_cnt;
    status_next = status;
    run_clear   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next  = RESET_HOLD;
          hold_next   = '0;
          status_next = STATUS_NONE;
          run_clear   = 1'b1;
        end
      end
      RESET_HOLD: begin
        if (hold_cnt == HW'(RST_CYCLES - 1)) state_next = RUN;
        else hold_next = hold_cnt + HW'(1);
      end
      RUN: begin
        if (halt) begin
          state_next  = DONE;
          status_next = STATUS_HALT;
        end else if (timeout) begin
          state_next  = DONE;
          status_next = STATUS_TIMEOUT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Run-cycle counter and repeated-PC detection.
  always_ff @(posedge clk) begin
    if (rst || run_clear) begin
      cycle_count <= '0;
      stall_cnt   <= '0;
      prev_pc     <= '0;
      prev_valid  <= 1'b0;
    end else if (in_run) begin
      cycle_count <= cycle_inc;
      stall_cnt   <= stall_next;
      prev_pc     <= pc_in;
      prev_valid  <= 1'b1;
    end
  end

  mips_trace_buf #(
    .PC_WIDTH   (PC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .TRACE_DEPTH(TRACE_DEPTH)
  ) u_trace (
    .clk   (clk),
    .rst   (rst),
    .clear (run_clear),
    .wr_en (in_run),
    .wr_pc (pc_in),
    .wr_alu(alu_in),
    .count (trace_count),
    .rd    (trace_bus)
  );
endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed bench for mips_run_monitor: four instances cover defaults,
// timeout with and without buffer wrap, and simultaneous halt/timeout.
module tb_mips_run_monitor;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_w     [4];
  logic [15:0] pc_w        [4];
  logic [15:0] alu_w       [4];
  logic        cpu_rst_n_w [4];
  logic        running_w   [4];
  logic        done_w      [4];
  logic [1:0]  status_w    [4];
  logic [31:0] cycle_w     [4];
  logic [4:0]  tc0, tc1, tc3;
  logic [5:0]  tc2;
  int          checks   = 0;
  int          failures = 0;
  int          samples;

  always #5 clk = ~clk;

  mips_run_monitor_if                    bus0 ();
  mips_run_monitor_if #(.TRACE_DEPTH(16)) bus1 ();
  mips_run_monitor_if #(.TRACE_DEPTH(32)) bus2 ();
  mips_run_monitor_if                    bus3 ();

  mips_run_monitor dut0 (
    .clk(clk), .rst(rst), .start(start_w[0]), .pc_in(pc_w[0]), .alu_in(alu_w[0]),
    .cpu_rst_n(cpu_rst_n_w[0]), .running(running_w[0]), .done(done_w[0]),
    .status(status_w[0]), .cycle_count(cycle_w[0]), .trace_count(tc0),
    .trace_bus(bus0.slave)
  );

  mips_run_monitor #(.MAX_CYCLES(20), .TRACE_DEPTH(16)) dut1 (
    .clk(clk), .rst(rst), .start(start_w[1]), .pc_in(pc_w[1]), .alu_in(alu_w[1]),
    .cpu_rst_n(cpu_rst_n_w[1]), .running(running_w[1]), .done(done_w[1]),
    .status(status_w[1]), .cycle_count(cycle_w[1]), .trace_count(tc1),
    .trace_bus(bus1.slave)
  );

  mips_run_monitor #(.MAX_CYCLES(20), .TRACE_DEPTH(32)) dut2 (
    .clk(clk), .rst(rst), .start(start_w[1]), .pc_in(pc_w[1]), .alu_in(alu_w[1]),
    .cpu_rst_n(cpu_rst_n_w[2]), .running(running_w[2]), .done(done_w[2]),
    .status(status_w[2]), .cycle_count(cycle_w[2]), .trace_count(tc2),
    .trace_bus(bus2.slave)
  );

  mips_run_monitor #(.MAX_CYCLES(9), .STALL_LIMIT(8)) dut3 (
    .clk(clk), .rst(rst), .start(start_w[3]), .pc_in(pc_w[3]), .alu_in(alu_w[3]),
    .cpu_rst_n(cpu_rst_n_w[3]), .running(running_w[3]), .done(done_w[3]),
    .status(status_w[3]), .cycle_count(cycle_w[3]), .trace_count(tc3),
    .trace_bus(bus3.slave)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [5:0] tcOf(input int which);
    case (which)
      0:       return {1'b0, tc0};
      1:       return {1'b0, tc1};
      2:       return tc2;
      default: return {1'b0, tc3};
    endcase
  endfunction

  function automatic logic [15:0] pcFor(input int mode, input int s);
    case (mode)
      0:       return (s < 4) ? 16'(2 * s) : 16'd6;
      1:       return 16'(2 * s);
      default: return 16'h0040;
    endcase
  endfunction

  task automatic setRd(input int which, input logic en, input int addr);
    case (which)
      0: begin bus0.trace_rd_en = en; bus0.trace_rd_addr = 4'(addr); end
      1: begin bus1.trace_rd_en = en; bus1.trace_rd_addr = 4'(addr); end
      2: begin bus2.trace_rd_en = en; bus2.trace_rd_addr = 5'(addr); end
      default: begin bus3.trace_rd_en = en; bus3.trace_rd_addr = 4'(addr); end
    endcase
  endtask

  task automatic getRd(input int which, output logic [15:0] rpc,
                       output logic [15:0] ralu, output logic rv);
    case (which)
      0: begin rpc = bus0.trace_pc; ralu = bus0.trace_alu; rv = bus0.trace_valid; end
      1: begin rpc = bus1.trace_pc; ralu = bus1.trace_alu; rv = bus1.trace_valid; end
      2: begin rpc = bus2.trace_pc; ralu = bus2.trace_alu; rv = bus2.trace_valid; end
      default: begin rpc = bus3.trace_pc; ralu = bus3.trace_alu; rv = bus3.trace_valid; end
    endcase
  endtask

  // One read request; data and valid one cycle later, valid drops after.
  task automatic readTrace(input int which, input int addr, input logic [15:0] exp_pc,
                           input logic [15:0] exp_alu, input string tag);
    logic [15:0] rpc, ralu;
    logic        rv;
    setRd(which, 1'b1, addr);
    @(negedge clk);
    getRd(which, rpc, ralu, rv);
    checkOutput({tag, "_valid"}, 64'(rv), 64'd1);
    checkOutput({tag, "_pc"}, 64'(rpc), 64'(exp_pc));
    checkOutput({tag, "_alu"}, 64'(ralu), 64'(exp_alu));
    setRd(which, 1'b0, 0);
    @(negedge clk);
    getRd(which, rpc, ralu, rv);
    checkOutput({tag, "_valid_end"}, 64'(rv), 64'd0);
  endtask

  // Pulse start from IDLE/DONE and confirm the CPU is held for 4 cycles.
  task automatic startRun(input int which, input string tag);
    int low;
    start_w[which] = 1'b1;
    @(negedge clk);
    start_w[which] = 1'b0;
    checkOutput({tag, "_status_clr"}, 64'(status_w[which]), 64'd0);
    checkOutput({tag, "_cycle_clr"}, 64'(cycle_w[which]), 64'd0);
    checkOutput({tag, "_tcount_clr"}, 64'(tcOf(which)), 64'd0);
    checkOutput({tag, "_done_clr"}, 64'(done_w[which]), 64'd0);
    low = 0;
    while (!cpu_rst_n_w[which] && low < 32) begin
      low++;
      @(negedge clk);
    end
    checkOutput({tag, "_hold_cycles"}, 64'(low), 64'd4);
    checkOutput({tag, "_running"}, 64'(running_w[which]), 64'd1);
  endtask

  // Feed a pc pattern each RUN cycle until done or the budget runs out.
  task automatic applyStimulus(input int which, input int mode, input int budget,
                               output int n);
    n = 0;
    while (!done_w[which] && n < budget) begin
      pc_w[which]  = pcFor(mode, n);
      alu_w[which] = pcFor(mode, n) ^ 16'hA5A5;
      @(negedge clk);
      n++;
    end
    checkOutput("run_reached_done", 64'(done_w[which]), 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_w[i] = 1'b0;
      pc_w[i]    = '0;
      alu_w[i]   = '0;
      setRd(i, 1'b0, 0);
    end
    repeat (3) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_cpu_rst_n", 64'(cpu_rst_n_w[0]), 64'd0);
    checkOutput("rst_running", 64'(running_w[0]), 64'd0);
    checkOutput("rst_done", 64'(done_w[0]), 64'd0);
    checkOutput("rst_status", 64'(status_w[0]), 64'd0);
    checkOutput("rst_cycle", 64'(cycle_w[0]), 64'd0);
    checkOutput("rst_tcount", 64'(tcOf(0)), 64'd0);
    checkOutput("rst_trace_pc", 64'(bus0.trace_pc), 64'd0);
    checkOutput("rst_trace_alu", 64'(bus0.trace_alu), 64'd0);
    checkOutput("rst_trace_valid", 64'(bus0.trace_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_cpu_rst_n", 64'(cpu_rst_n_w[0]), 64'd0);

    $display("[TB] halt run");
    startRun(0, "halt");
    applyStimulus(0, 0, 64, samples);
    checkOutput("halt_samples", 64'(samples), 64'd12);
    checkOutput("halt_status", 64'(status_w[0]), 64'd1);
    checkOutput("halt_cycle", 64'(cycle_w[0]), 64'd12);
    checkOutput("halt_tcount", 64'(tcOf(0)), 64'd12);
    checkOutput("halt_cpu_rst_n", 64'(cpu_rst_n_w[0]), 64'd0);
    checkOutput("halt_running", 64'(running_w[0]), 64'd0);
    readTrace(0, 0, 16'd0, 16'd0 ^ 16'hA5A5, "halt_rd0");
    readTrace(0, 11, 16'd6, 16'd6 ^ 16'hA5A5, "halt_rd11");
    readTrace(0, 2, 16'd4, 16'd4 ^ 16'hA5A5, "halt_rd2");

    $display("[TB] timeout run, depth 16 and 32");
    startRun(1, "tmo");
    applyStimulus(1, 1, 64, samples);
    checkOutput("tmo_samples", 64'(samples), 64'd20);
    checkOutput("tmo_status", 64'(status_w[1]), 64'd2);
    checkOutput("tmo_cycle", 64'(cycle_w[1]), 64'd20);
    checkOutput("tmo_tcount", 64'(tcOf(1)), 64'd16);
    checkOutput("tmo32_done", 64'(done_w[2]), 64'd1);
    checkOutput("tmo32_status", 64'(status_w[2]), 64'd2);
    checkOutput("tmo32_cycle", 64'(cycle_w[2]), 64'd20);
    checkOutput("tmo32_tcount", 64'(tcOf(2)), 64'd20);
    readTrace(1, 0, 16'd8, 16'd8 ^ 16'hA5A5, "tmo_rd0");
    readTrace(1, 15, 16'd38, 16'd38 ^ 16'hA5A5, "tmo_rd15");
    readTrace(2, 0, 16'd0, 16'd0 ^ 16'hA5A5, "tmo32_rd0");
    readTrace(2, 19, 16'd38, 16'd38 ^ 16'hA5A5, "tmo32_rd19");
    readTrace(2, 20, 16'd0, 16'd0, "tmo32_rd20");

    $display("[TB] simultaneous halt and timeout");
    startRun(3, "sim");
    applyStimulus(3, 2, 64, samples);
    checkOutput("sim_samples", 64'(samples), 64'd9);
    checkOutput("sim_status", 64'(status_w[3]), 64'd1);
    checkOutput("sim_cycle", 64'(cycle_w[3]), 64'd9);
    checkOutput("sim_tcount", 64'(tcOf(3)), 64'd9);
    readTrace(3, 8, 16'h0040, 16'h0040 ^ 16'hA5A5, "sim_rd8");

    $display("[TB] restart from done");
    startRun(0, "rerun");
    applyStimulus(0, 0, 64, samples);
    checkOutput("rerun_samples", 64'(samples), 64'd12);
    checkOutput("rerun_status", 64'(status_w[0]), 64'd1);
    checkOutput("rerun_cycle", 64'(cycle_w[0]), 64'd12);
    checkOutput("rerun_tcount", 64'(tcOf(0)), 64'd12);
    readTrace(0, 0, 16'd0, 16'd0 ^ 16'hA5A5, "rerun_rd0");
    readTrace(0, 11, 16'd6, 16'd6 ^ 16'hA5A5, "rerun_rd11");

    $display("[TB] start ignored in run, then reset mid-run");
    startRun(0, "mid");
    for (int s = 0; s < 5; s++) begin
      pc_w[0]    = pcFor(1, s);
      alu_w[0]   = 16'h1234;
      start_w[0] = (s == 2);
      @(negedge clk);
    end
    start_w[0] = 1'b0;
    checkOutput("mid_running", 64'(running_w[0]), 64'd1);
    checkOutput("mid_cycle", 64'(cycle_w[0]), 64'd5);
    checkOutput("mid_tcount", 64'(tcOf(0)), 64'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_running", 64'(running_w[0]), 64'd0);
    checkOutput("midrst_done", 64'(done_w[0]), 64'd0);
    checkOutput("midrst_cpu_rst_n", 64'(cpu_rst_n_w[0]), 64'd0);
    checkOutput("midrst_cycle", 64'(cycle_w[0]), 64'd0);
    checkOutput("midrst_tcount", 64'(tcOf(0)), 64'd0);
    @(negedge clk);
    checkOutput("midrst_stays_idle", 64'(cpu_rst_n_w[0]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
